// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the LSU data-memory access stage.
package lsu_mem_ctrl_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned SIZE_W_ = 2;
    localparam int unsigned CAUSE_W = 4;

    // Access size encodings (3 is illegal and handled as a word)
    localparam logic [SIZE_W_-1:0] SIZE_B = 2'd0;
    localparam logic [SIZE_W_-1:0] SIZE_H = 2'd1;
    localparam logic [SIZE_W_-1:0] SIZE_W = 2'd2;

    // Exception causes reported on the response
    localparam logic [CAUSE_W-1:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [CAUSE_W-1:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [CAUSE_W-1:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [CAUSE_W-1:0] EXC_ST_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FAULT = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic               load;
        logic [SIZE_W_-1:0] size;
        logic [XLEN-1:0]    addr;
        logic [XLEN-1:0]    sdata;
    } lsu_mem_req_type;

    typedef struct packed {
        logic [XLEN-1:0]    ldata;
        logic [BE_W-1:0]    byteenable;
        logic               exc;
        logic [CAUSE_W-1:0] ecause;
    } lsu_mem_rsp_type;

    // Cause code for a failed access: misalignment or bus fault, load or store
    function automatic logic [CAUSE_W-1:0] exc_cause(input logic load, input logic misalign);
        if (misalign) return load ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
        return load ? EXC_LD_FAULT : EXC_ST_FAULT;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request, data-bus and response signals of the LSU memory access stage.
interface lsu_mem_ctrl_if;
    import lsu_mem_ctrl_pkg::*;

    logic                 flush;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_load;
    logic [SIZE_W_-1:0]   req_size;
    logic [XLEN-1:0]      req_addr;
    logic [XLEN-1:0]      req_sdata;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [XLEN-1:0]      mem_addr;
    logic [XLEN-1:0]      mem_wdata;
    logic [BE_W-1:0]      mem_wstrb;
    logic [XLEN-1:0]      mem_rdata;
    logic                 rsp_valid;
    logic [XLEN-1:0]      rsp_ldata;
    logic [BE_W-1:0]      rsp_byteenable;
    logic                 rsp_exc;
    logic [CAUSE_W-1:0]   rsp_ecause;

    // View of the access stage itself
    modport slave (
        input  flush, req_valid, req_load, req_size, req_addr, req_sdata,
        input  mem_ready, mem_rdata,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output rsp_valid, rsp_ldata, rsp_byteenable, rsp_exc, rsp_ecause
    );

    // View of execute plus data memory around the stage
    modport master (
        output flush, req_valid, req_load, req_size, req_addr, req_sdata,
        output mem_ready, mem_rdata,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  rsp_valid, rsp_ldata, rsp_byteenable, rsp_exc, rsp_ecause
    );

endinterface

// File: rtl/lsu_mem_ctrl_dmem_align.sv
// Byte-lane steering: byteenable, replicated store data and misalignment check.
module lsu_mem_ctrl_dmem_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [SIZE_W_-1:0] size,
    input  logic [1:0]         addr_lo,
    input  logic [XLEN-1:0]    sdata,
    output logic [BE_W-1:0]    byteenable_c,
    output logic [XLEN-1:0]    wdata_c,
    output logic               misalign_c
);

    // Lane selection per access size; size 3 falls through to word
    always_comb begin
        byteenable_c = 4'hF;
        wdata_c      = sdata;
        misalign_c   = 1'b0;
        case (size)
            SIZE_B: begin
                byteenable_c = 4'b0001 << addr_lo;
                wdata_c      = {4{sdata[7:0]}};
            end
            SIZE_H: begin
                byteenable_c = addr_lo[1] ? 4'hC : 4'h3;
                wdata_c      = {2{sdata[15:0]}};
                misalign_c   = addr_lo[0];
            end
            default: begin
                byteenable_c = 4'hF;
                wdata_c      = sdata;
                misalign_c   = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Data-memory access stage: one outstanding load/store, bus handshake, raw response.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 0
) (
    input logic           clock,
    input logic           reset,
    lsu_mem_ctrl_if.slave bus
);

    localparam int unsigned       CNT_W     = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LAST = (WAIT_MAX == 0) ? '0 : CNT_W'(WAIT_MAX - 1);

    lsu_mem_req_type  req_c;
    logic [BE_W-1:0]  be_c;
    logic [XLEN-1:0]  wdata_c;
    logic             misalign_c;
    logic             accept_c;
    logic             timeout_c;

    lsu_state_e       state_q, state_nxt;
    logic             req_ready_q;
    logic             mem_valid_q;
    logic [XLEN-1:0]  mem_addr_q;
    logic [XLEN-1:0]  mem_wdata_q;
    logic [BE_W-1:0]  mem_wstrb_q;
    logic             load_q;
    logic [BE_W-1:0]  be_q;
    logic             flushed_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             rsp_valid_q;
    lsu_mem_rsp_type  rsp_q;

    assign req_c = '{load: bus.req_load, size: bus.req_size,
                     addr: bus.req_addr, sdata: bus.req_sdata};

    lsu_mem_ctrl_dmem_align u_align (
        .size         (req_c.size),
        .addr_lo      (req_c.addr[1:0]),
        .sdata        (req_c.sdata),
        .byteenable_c (be_c),
        .wdata_c      (wdata_c),
        .misalign_c   (misalign_c)
    );

    assign accept_c = (state_q == ST_IDLE) && bus.req_valid && !bus.flush;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    // Next state; a bus completion in the last allowed wait cycle beats the timeout
    always_comb begin
        state_nxt = state_q;
        timeout_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) state_nxt = misalign_c ? ST_FAULT : ST_BUSY;
            end
            ST_BUSY: begin
                if (bus.mem_ready) begin
                    state_nxt = ST_IDLE;
                end else if ((WAIT_MAX != 0) && (wait_cnt_q == WAIT_LAST)) begin
                    state_nxt = ST_IDLE;
                    timeout_c = 1'b1;
                end
            end
            ST_FAULT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs, transaction context and response registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            req_ready_q <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            load_q      <= 1'b0;
            be_q        <= '0;
            flushed_q   <= 1'b0;
            wait_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            req_ready_q <= (state_nxt == ST_IDLE);
            mem_valid_q <= (state_nxt == ST_BUSY);
            rsp_valid_q <= 1'b0;
            if (accept_c) begin
                load_q     <= req_c.load;
                be_q       <= be_c;
                flushed_q  <= 1'b0;
                wait_cnt_q <= '0;
                if (misalign_c) begin
                    rsp_valid_q <= 1'b1;
                    rsp_q       <= '{ldata: '0, byteenable: be_c, exc: 1'b1,
                                     ecause: exc_cause(req_c.load, 1'b1)};
                end else begin
                    mem_addr_q  <= {req_c.addr[XLEN-1:2], 2'b00};
                    mem_wdata_q <= wdata_c;
                    mem_wstrb_q <= req_c.load ? '0 : be_c;
                end
            end
            if (state_q == ST_BUSY) begin
                // A flush never abandons the bus cycle; it only hides the response
                if (bus.flush) flushed_q <= 1'b1;
                if (!bus.mem_ready && (WAIT_MAX != 0)) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                if ((bus.mem_ready || timeout_c) && !(flushed_q || bus.flush)) begin
                    rsp_valid_q      <= 1'b1;
                    rsp_q.ldata      <= (bus.mem_ready && load_q) ? bus.mem_rdata : '0;
                    rsp_q.byteenable <= be_q;
                    rsp_q.exc        <= timeout_c;
                    rsp_q.ecause     <= timeout_c ? exc_cause(load_q, 1'b0) : '0;
                end
            end
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.mem_valid      = mem_valid_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.mem_wstrb      = mem_wstrb_q;
    // A misalignment response is already presented in the FAULT cycle, so a flush
    // arriving in that same cycle can only be honoured by masking the pulse
    assign bus.rsp_valid      = rsp_valid_q && !((state_q == ST_FAULT) && bus.flush);
    assign bus.rsp_ldata      = rsp_q.ldata;
    assign bus.rsp_byteenable = rsp_q.byteenable;
    assign bus.rsp_exc        = rsp_q.exc;
    assign bus.rsp_ecause     = rsp_q.ecause;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl with a response scoreboard.
module tb_lsu_mem_ctrl;
    import lsu_mem_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;

    lsu_mem_rsp_type exp_q[$];
    lsu_mem_rsp_type mon_e;

    typedef struct {
        logic        load;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  be;
        int          waits;
    } vec_t;

    lsu_mem_ctrl_if bus();

    lsu_mem_ctrl #(.WAIT_MAX(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Scoreboard: every response pulse must match the oldest expected entry
    always @(negedge clock) begin
        if (bus.rsp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rsp_unexpected: got ldata=%h be=%h exc=%b cause=%0d with nothing expected",
                         bus.rsp_ldata, bus.rsp_byteenable, bus.rsp_exc, bus.rsp_ecause);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.rsp_ldata, bus.rsp_byteenable, bus.rsp_exc, bus.rsp_ecause} !==
                    {mon_e.ldata, mon_e.byteenable, mon_e.exc, mon_e.ecause})
                    $display("FAIL rsp_fields: got ldata=%h be=%h exc=%b cause=%0d expected ldata=%h be=%h exc=%b cause=%0d",
                             bus.rsp_ldata, bus.rsp_byteenable, bus.rsp_exc, bus.rsp_ecause,
                             mon_e.ldata, mon_e.byteenable, mon_e.exc, mon_e.ecause);
                else passed++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input logic load, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] sdata);
        bus.req_valid = 1'b1;
        bus.req_load  = load;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_sdata = sdata;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if ({bus.req_ready, bus.mem_valid, bus.rsp_valid, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata} !==
            {1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0})
            $display("FAIL reset_bus: got rdy=%b mv=%b rv=%b strb=%h addr=%h wdata=%h expected rdy=1 others 0",
                     bus.req_ready, bus.mem_valid, bus.rsp_valid, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata);
        else passed++;
        checks++;
        if ({bus.rsp_ldata, bus.rsp_byteenable, bus.rsp_exc, bus.rsp_ecause} !== 41'h0)
            $display("FAIL reset_rsp: got ldata=%h be=%h exc=%b cause=%0d expected all 0",
                     bus.rsp_ldata, bus.rsp_byteenable, bus.rsp_exc, bus.rsp_ecause);
        else passed++;
        next_cycle();
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic test_load_word();
        drive_req(1'b1, SIZE_W, 32'h100, 32'h0);
        @(negedge clock);
        checks++;
        if (bus.req_ready !== 1'b1) $display("FAIL lw_req_ready: got %b expected 1", bus.req_ready);
        else passed++;
        exp_q.push_back('{ldata: 32'hDEADBEEF, byteenable: 4'hF, exc: 1'b0, ecause: 4'd0});
        next_cycle();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clock);
        checks++;
        if ({bus.mem_valid, bus.mem_addr, bus.mem_wstrb} !== {1'b1, 32'h100, 4'h0})
            $display("FAIL lw_bus_n1: got mv=%b addr=%h strb=%h expected mv=1 addr=00000100 strb=0",
                     bus.mem_valid, bus.mem_addr, bus.mem_wstrb);
        else passed++;
        next_cycle();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        @(negedge clock);
        checks++;
        if ({bus.rsp_valid, bus.mem_valid} !== 2'b10)
            $display("FAIL lw_rsp_n2: got rv=%b mv=%b expected rv=1 mv=0", bus.rsp_valid, bus.mem_valid);
        else passed++;
        next_cycle();
        @(negedge clock);
        checks++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL lw_single_pulse: got rv=%b expected 0", bus.rsp_valid);
        else passed++;
        next_cycle();
    endtask

    task automatic test_aligned();
        vec_t vecs[7];
        vecs[0] = '{1'b0, SIZE_B, 32'h203, 32'h000000A5, 32'h0, 32'h200, 32'hA5A5A5A5, 4'h8, 4'h8, 0};
        vecs[1] = '{1'b0, SIZE_H, 32'h102, 32'hFFFF1234, 32'h0, 32'h100, 32'h12341234, 4'hC, 4'hC, 1};
        vecs[2] = '{1'b0, SIZE_W, 32'h208, 32'h12345678, 32'h0, 32'h208, 32'h12345678, 4'hF, 4'hF, 2};
        vecs[3] = '{1'b1, SIZE_B, 32'h101, 32'h0, 32'h11223344, 32'h100, 32'h0, 4'h0, 4'h2, 3};
        vecs[4] = '{1'b1, SIZE_H, 32'h202, 32'h0, 32'hAABBCCDD, 32'h200, 32'h0, 4'h0, 4'hC, 0};
        vecs[5] = '{1'b0, 2'd3, 32'h010, 32'h87654321, 32'h0, 32'h010, 32'h87654321, 4'hF, 4'hF, 1};
        vecs[6] = '{1'b1, SIZE_W, 32'h304, 32'h0000005A, 32'h13579BDF, 32'h304, 32'h0000005A, 4'h0, 4'hF, 0};
        foreach (vecs[i]) begin
            drive_req(vecs[i].load, vecs[i].size, vecs[i].addr, vecs[i].sdata);
            exp_q.push_back('{ldata: vecs[i].load ? vecs[i].rdata : 32'h0, byteenable: vecs[i].be,
                              exc: 1'b0, ecause: 4'd0});
            next_cycle();
            bus.req_valid = 1'b0;
            for (int w = 0; w <= vecs[i].waits; w++) begin
                if (w == vecs[i].waits) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = vecs[i].rdata;
                end
                @(negedge clock);
                checks++;
                if ({bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !==
                    {1'b1, vecs[i].maddr, vecs[i].wdata, vecs[i].wstrb})
                    $display("FAIL aligned_bus[%0d] wait %0d: got mv=%b addr=%h wdata=%h strb=%h expected mv=1 addr=%h wdata=%h strb=%h",
                             i, w, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb,
                             vecs[i].maddr, vecs[i].wdata, vecs[i].wstrb);
                else passed++;
                next_cycle();
            end
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 32'h0;
            @(negedge clock);
            checks++;
            if (bus.rsp_valid !== 1'b1) $display("FAIL aligned_rsp[%0d]: got rv=%b expected 1", i, bus.rsp_valid);
            else passed++;
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        drive_req(1'b1, SIZE_W, 32'h500, 32'h0);
        exp_q.push_back('{ldata: 32'h01010101, byteenable: 4'hF, exc: 1'b0, ecause: 4'd0});
        next_cycle();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h01010101;
        next_cycle();
        bus.mem_ready = 1'b0;
        drive_req(1'b1, SIZE_W, 32'h504, 32'h0);
        @(negedge clock);
        checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b11)
            $display("FAIL b2b_accept: got rv=%b rdy=%b expected rv=1 rdy=1", bus.rsp_valid, bus.req_ready);
        else passed++;
        exp_q.push_back('{ldata: 32'h02020202, byteenable: 4'hF, exc: 1'b0, ecause: 4'd0});
        next_cycle();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h02020202;
        @(negedge clock);
        checks++;
        if ({bus.mem_valid, bus.mem_addr, bus.rsp_valid} !== {1'b1, 32'h504, 1'b0})
            $display("FAIL b2b_second_bus: got mv=%b addr=%h rv=%b expected mv=1 addr=00000504 rv=0",
                     bus.mem_valid, bus.mem_addr, bus.rsp_valid);
        else passed++;
        next_cycle();
        bus.mem_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.rsp_valid !== 1'b1) $display("FAIL b2b_second_rsp: got rv=%b expected 1", bus.rsp_valid);
        else passed++;
        next_cycle();
    endtask

    task automatic test_misalign();
        logic        ld[4]    = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0]  sz[4]    = '{SIZE_H, SIZE_W, SIZE_H, SIZE_W};
        logic [31:0] ad[4]    = '{32'h101, 32'h102, 32'h203, 32'h301};
        logic [3:0]  be[4]    = '{4'h3, 4'hF, 4'hC, 4'hF};
        logic [3:0]  cause[4] = '{4'd4, 4'd6, 4'd6, 4'd4};
        for (int i = 0; i < 4; i++) begin
            drive_req(ld[i], sz[i], ad[i], 32'h55AA55AA);
            exp_q.push_back('{ldata: 32'h0, byteenable: be[i], exc: 1'b1, ecause: cause[i]});
            next_cycle();
            bus.req_valid = 1'b0;
            @(negedge clock);
            checks++;
            if ({bus.mem_valid, bus.rsp_valid} !== 2'b01)
                $display("FAIL misalign_n1[%0d]: got mv=%b rv=%b expected mv=0 rv=1", i, bus.mem_valid, bus.rsp_valid);
            else passed++;
            next_cycle();
            @(negedge clock);
            checks++;
            if ({bus.mem_valid, bus.rsp_valid, bus.req_ready} !== 3'b001)
                $display("FAIL misalign_n2[%0d]: got mv=%b rv=%b rdy=%b expected mv=0 rv=0 rdy=1",
                         i, bus.mem_valid, bus.rsp_valid, bus.req_ready);
            else passed++;
            next_cycle();
        end
    endtask

    task automatic test_timeout();
        logic ld[3]       = '{1'b1, 1'b1, 1'b0};
        int   ready_at[3] = '{-1, 3, -1};
        for (int v = 0; v < 3; v++) begin
            drive_req(ld[v], SIZE_W, 32'h600, 32'h0);
            if (ready_at[v] >= 0)
                exp_q.push_back('{ldata: 32'hCAFEF00D, byteenable: 4'hF, exc: 1'b0, ecause: 4'd0});
            else
                exp_q.push_back('{ldata: 32'h0, byteenable: 4'hF, exc: 1'b1,
                                  ecause: ld[v] ? 4'd5 : 4'd7});
            next_cycle();
            bus.req_valid = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (c == ready_at[v]) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = 32'hCAFEF00D;
                end
                @(negedge clock);
                checks++;
                if (bus.mem_valid !== 1'b1)
                    $display("FAIL timeout_hold[%0d] cycle %0d: got mv=%b expected 1", v, c, bus.mem_valid);
                else passed++;
                next_cycle();
            end
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 32'h0;
            @(negedge clock);
            checks++;
            if ({bus.mem_valid, bus.rsp_valid, bus.req_ready} !== 3'b011)
                $display("FAIL timeout_end[%0d]: got mv=%b rv=%b rdy=%b expected mv=0 rv=1 rdy=1",
                         v, bus.mem_valid, bus.rsp_valid, bus.req_ready);
            else passed++;
            next_cycle();
        end
    endtask

    task automatic test_flush();
        // flush beats a simultaneous request in IDLE
        bus.flush = 1'b1;
        drive_req(1'b1, SIZE_W, 32'h700, 32'h0);
        next_cycle();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.mem_valid, bus.req_ready, bus.rsp_valid} !== 3'b010)
            $display("FAIL flush_idle: got mv=%b rdy=%b rv=%b expected mv=0 rdy=1 rv=0",
                     bus.mem_valid, bus.req_ready, bus.rsp_valid);
        else passed++;
        next_cycle();
        // flush while BUSY: bus cycle runs to completion, response hidden
        drive_req(1'b1, SIZE_W, 32'h704, 32'h0);
        next_cycle();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'h0BADF00D;
            end
            @(negedge clock);
            checks++;
            if ({bus.mem_valid, bus.mem_addr} !== {1'b1, 32'h704})
                $display("FAIL flush_busy_hold cycle %0d: got mv=%b addr=%h expected mv=1 addr=00000704",
                         c, bus.mem_valid, bus.mem_addr);
            else passed++;
            next_cycle();
        end
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        @(negedge clock);
        checks++;
        if ({bus.mem_valid, bus.rsp_valid, bus.req_ready} !== 3'b001)
            $display("FAIL flush_busy_done: got mv=%b rv=%b rdy=%b expected mv=0 rv=0 rdy=1",
                     bus.mem_valid, bus.rsp_valid, bus.req_ready);
        else passed++;
        next_cycle();
        drive_req(1'b1, SIZE_W, 32'h708, 32'h0);
        exp_q.push_back('{ldata: 32'h600DF00D, byteenable: 4'hF, exc: 1'b0, ecause: 4'd0});
        next_cycle();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h600DF00D;
        next_cycle();
        bus.mem_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.rsp_valid !== 1'b1) $display("FAIL flush_next_req: got rv=%b expected 1", bus.rsp_valid);
        else passed++;
        next_cycle();
        // flush during the FAULT cycle hides the exception response
        drive_req(1'b1, SIZE_H, 32'h101, 32'h0);
        next_cycle();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b1;
        @(negedge clock);
        checks++;
        if ({bus.rsp_valid, bus.mem_valid} !== 2'b00)
            $display("FAIL flush_fault: got rv=%b mv=%b expected rv=0 mv=0", bus.rsp_valid, bus.mem_valid);
        else passed++;
        next_cycle();
        bus.flush = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01)
            $display("FAIL flush_fault_after: got rv=%b rdy=%b expected rv=0 rdy=1", bus.rsp_valid, bus.req_ready);
        else passed++;
        next_cycle();
    endtask

    task automatic test_reset_busy();
        for (int r = 0; r < 2; r++) begin
            drive_req(1'b1, SIZE_W, 32'h800, 32'h0);
            next_cycle();
            bus.req_valid = 1'b0;
            @(negedge clock);
            checks++;
            if (bus.mem_valid !== 1'b1) $display("FAIL rst_busy_pre[%0d]: got mv=%b expected 1", r, bus.mem_valid);
            else passed++;
            next_cycle();
            reset         = 1'b0;
            bus.mem_ready = (r == 1);
            bus.mem_rdata = 32'h12121212;
            next_cycle();
            reset         = 1'b1;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 32'h0;
            @(negedge clock);
            checks++;
            if ({bus.mem_valid, bus.req_ready, bus.rsp_valid} !== 3'b010)
                $display("FAIL rst_busy_post[%0d]: got mv=%b rdy=%b rv=%b expected mv=0 rdy=1 rv=0",
                         r, bus.mem_valid, bus.req_ready, bus.rsp_valid);
            else passed++;
            next_cycle();
            @(negedge clock);
            checks++;
            if ({bus.mem_valid, bus.rsp_valid} !== 2'b00)
                $display("FAIL rst_busy_quiet[%0d]: got mv=%b rv=%b expected 0 0", r, bus.mem_valid, bus.rsp_valid);
            else passed++;
            next_cycle();
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_load  = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_addr  = 32'h0;
        bus.req_sdata = 32'h0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_load_word();
        test_aligned();
        test_back_to_back();
        test_misalign();
        test_timeout();
        test_flush();
        test_reset_busy();
        repeat (2) next_cycle();
        checks++;
        if (exp_q.size() != 0) $display("FAIL rsp_missing: %0d expected responses never arrived", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
